// File: rtl/dsp48a1_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp48a1_mac_sequencer
// Description : Drives one dsp48a1 slice as an N-term multiply-accumulator,
//               P = sum(+/- A_i * B_i). Operand pairs arrive on a
//               valid/ready stream. The sequencer clears the slice, feeds
//               the operands with a delayed OPMODE per beat, waits for the
//               slice pipeline to drain and returns the 48-bit sum with a
//               one-cycle strobe.
//               Slice build: A1REG=B1REG=MREG=PREG=OPMODEREG=1,
//               A0REG=B0REG=DREG=CREG=CARRYINREG=0.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp48a1_mac_sequencer #(
    parameter int LAT     = 3,  // DSP_A/B driven -> product visible on DSP_P
    parameter int OPM_DLY = 1,  // operand driven -> its OPMODE driven
    parameter int NW      = 8   // width of the tap count
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [NW-1:0] ntaps_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [17:0]   s_a_i,
    input  logic [17:0]   s_b_i,
    input  logic          s_sub_i,
    output logic [17:0]   dsp_a_o,
    output logic [17:0]   dsp_b_o,
    output logic [7:0]    dsp_opmode_o,
    output logic          dsp_ce_o,
    output logic          dsp_rst_o,
    input  logic [47:0]   dsp_p_i,
    output logic [47:0]   res_o,
    output logic          res_valid_o,
    output logic          busy_o,
    output logic          err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLR   = 2'd1;
    localparam logic [1:0] S_FEED  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // X=M, Z=P: P <= P + M ; with bit 7 set: P <= P - M
    localparam logic [7:0] C_OPM_ADD = 8'h09;
    localparam logic [7:0] C_OPM_SUB = 8'h89;
    localparam logic [7:0] C_OPM_OFF = 8'h00;

    // DRAIN covers the LAT cycles following the last accepted beat; the
    // final cycle (counter at zero) is the one where DSP_P holds the sum.
    localparam int            DW           = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DW-1:0] C_DRAIN_LOAD = DW'(LAT - 1);
    localparam logic [NW-1:0] C_ONE        = NW'(1);

    // ------------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;        // beats still to accept
    logic [DW-1:0] drain_q, drain_d;    // cycles left until DSP_P is final
    logic [47:0]   res_q, res_d;
    logic          res_valid_q, res_valid_d;
    logic          err_q, err_d;
    logic          dsp_rst_q, dsp_rst_d;

    logic          accept;
    logic          opm_act_in;
    logic          opm_sub_in;
    logic          opm_act;
    logic          opm_sub;

    // ------------------------------------------------------------------------
    // Stream handshake and operand path
    // ------------------------------------------------------------------------
    assign busy_o    = (state_q != S_IDLE);
    assign dsp_ce_o  = busy_o;
    assign s_ready_o = (state_q == S_FEED) && (cnt_q != '0);
    assign accept    = s_valid_i && s_ready_o;

    // A cycle without an accepted beat is a bubble: zero operands add zero.
    assign dsp_a_o = accept ? s_a_i : 18'd0;
    assign dsp_b_o = accept ? s_b_i : 18'd0;

    // ------------------------------------------------------------------------
    // OPMODE path: the add/subtract choice for a beat reaches the slice
    // OPM_DLY cycles after its operands, matching the A1/B1 register stage.
    // The active flag forces OPMODE to zero whenever no job is running.
    // ------------------------------------------------------------------------
    assign opm_act_in = (state_d != S_IDLE);
    assign opm_sub_in = accept && s_sub_i;

    generate
        if (OPM_DLY == 0) begin : g_opm_direct
            assign opm_act = busy_o;
            assign opm_sub = opm_sub_in;
        end else begin : g_opm_pipe
            logic [OPM_DLY-1:0] act_q;
            logic [OPM_DLY-1:0] sub_q;

            // Delay line carrying the per-beat OPMODE choice
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    act_q <= '0;
                    sub_q <= '0;
                end else begin
                    act_q[0] <= opm_act_in;
                    sub_q[0] <= opm_sub_in;
                    for (int i = 1; i < OPM_DLY; i++) begin
                        act_q[i] <= act_q[i-1];
                        sub_q[i] <= sub_q[i-1];
                    end
                end
            end

            assign opm_act = act_q[OPM_DLY-1];
            assign opm_sub = sub_q[OPM_DLY-1];
        end
    endgenerate

    assign dsp_opmode_o = !opm_act ? C_OPM_OFF :
                          (opm_sub ? C_OPM_SUB : C_OPM_ADD);

    // ------------------------------------------------------------------------
    // Control FSM: IDLE -> CLR -> FEED -> DRAIN -> IDLE
    // ------------------------------------------------------------------------

    // Next-state, beat counter and drain counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                // START is only honoured here; NTAPS=0 is rejected via ERR
                if (start_i && (ntaps_i != '0)) begin
                    cnt_d   = ntaps_i;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                // One cycle of slice reset so P starts the job at zero
                state_d = S_FEED;
            end
            S_FEED: begin
                if (accept) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == C_ONE) begin
                        state_d = S_DRAIN;
                        drain_d = C_DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Result capture, strobes and slice reset request
    assign res_valid_d = (state_q == S_DRAIN) && (drain_q == '0);
    assign res_d       = res_valid_d ? dsp_p_i : res_q;
    assign err_d       = (state_q == S_IDLE) && start_i && (ntaps_i == '0);
    assign dsp_rst_d   = (state_d == S_CLR);

    // Sequential state; DSP_RST resets high so the slice flushes during reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            dsp_rst_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            dsp_rst_q   <= dsp_rst_d;
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = res_valid_q;
    assign err_o       = err_q;
    assign dsp_rst_o   = dsp_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp48a1_mac_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dsp48a1_mac_sequencer
// Description : Self-checking bench for dsp48a1_mac_sequencer. Contains a
//               behavioural stand-in for the dsp48a1 slice in its fixed
//               register configuration, and a reference sum computed with
//               plain 64-bit arithmetic over the job's operand list.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48a1_mac_sequencer;

    localparam int LAT     = 3;
    localparam int OPM_DLY = 1;
    localparam int NW      = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] ntaps;
    logic          s_valid;
    logic          s_ready;
    logic [17:0]   s_a;
    logic [17:0]   s_b;
    logic          s_sub;
    logic [17:0]   dsp_a;
    logic [17:0]   dsp_b;
    logic [7:0]    dsp_opmode;
    logic          dsp_ce;
    logic          dsp_rst;
    logic [47:0]   dsp_p;
    logic [47:0]   res;
    logic          res_valid;
    logic          busy;
    logic          err;

    dsp48a1_mac_sequencer #(
        .LAT     (LAT),
        .OPM_DLY (OPM_DLY),
        .NW      (NW)
    ) u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .ntaps_i      (ntaps),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_a_i        (s_a),
        .s_b_i        (s_b),
        .s_sub_i      (s_sub),
        .dsp_a_o      (dsp_a),
        .dsp_b_o      (dsp_b),
        .dsp_opmode_o (dsp_opmode),
        .dsp_ce_o     (dsp_ce),
        .dsp_rst_o    (dsp_rst),
        .dsp_p_i      (dsp_p),
        .res_o        (res),
        .res_valid_o  (res_valid),
        .busy_o       (busy),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // dsp48a1 stand-in: A1/B1, M, P and OPMODE registers, synchronous reset
    // with priority over clock enable.
    // ------------------------------------------------------------------------
    logic signed [17:0] sl_a1;
    logic signed [17:0] sl_b1;
    logic signed [35:0] sl_m;
    logic [7:0]         sl_opm;
    logic [47:0]        sl_p;
    logic [47:0]        sl_x;
    logic [47:0]        sl_z;

    always_comb begin
        sl_x = (sl_opm[1:0] == 2'b01) ? {{12{sl_m[35]}}, sl_m} : 48'd0;
        sl_z = (sl_opm[3:2] == 2'b10) ? sl_p : 48'd0;
    end

    always @(posedge clk) begin
        if (dsp_rst) begin
            sl_a1  <= '0;
            sl_b1  <= '0;
            sl_m   <= '0;
            sl_opm <= '0;
            sl_p   <= '0;
        end else if (dsp_ce) begin
            sl_a1  <= dsp_a;
            sl_b1  <= dsp_b;
            sl_m   <= sl_a1 * sl_b1;
            sl_opm <= dsp_opmode;
            sl_p   <= sl_opm[7] ? (sl_z - sl_x) : (sl_z + sl_x);
        end
    end

    assign dsp_p = sl_p;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Job description and reference model
    // ------------------------------------------------------------------------
    logic signed [17:0] ja [256];
    logic signed [17:0] jb [256];
    bit                 js [256];
    int                 jst[256];   // stall cycles before each beat
    logic [47:0]        exp_res;

    function automatic logic [47:0] ref_sum(input int n);
        longint acc;
        longint prod;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            prod = longint'(ja[i]) * longint'(jb[i]);
            if (js[i]) acc = acc - prod;
            else       acc = acc + prod;
        end
        return acc[47:0];
    endfunction

    function automatic logic [17:0] rand18();
        logic [17:0] v;
        case ($urandom_range(0, 5))
            0:       v = 18'h20000;  // -131072
            1:       v = 18'h1FFFF;  //  131071
            default: v = 18'($urandom);
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus tasks (all entered and left at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic run_job(input int n, input bit pulse_mid);
        int waited;
        bit acc;
        start = 1'b1;
        ntaps = NW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        check("clr_busy",     64'(busy),      64'd1);
        check("clr_dsp_rst",  64'(dsp_rst),   64'd1);
        check("clr_dsp_ce",   64'(dsp_ce),    64'd1);
        check("strobe_width", 64'(res_valid), 64'd0);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < jst[i]; k++) begin
                s_valid = 1'b0;
                s_a     = 18'($urandom);
                s_b     = 18'($urandom);
                if (pulse_mid && i == 1 && k == 0) begin
                    start = 1'b1;
                    ntaps = NW'($urandom_range(0, 3));
                end
                @(posedge clk); #1;
                start = 1'b0;
                check("stall_busy", 64'(busy), 64'd1);
                if (pulse_mid && i == 1 && k == 0)
                    check("busy_start_err", 64'(err), 64'd0);
            end
            s_a     = ja[i];
            s_b     = jb[i];
            s_sub   = js[i];
            s_valid = 1'b1;
            acc     = 1'b0;
            waited  = 0;
            while (!acc && waited < 8) begin
                acc = s_ready;
                @(posedge clk); #1;
                waited++;
            end
            s_valid = 1'b0;
            s_a     = 18'($urandom);
            s_b     = 18'($urandom);
            s_sub   = 1'($urandom);
            check("beat_accept", 64'(acc), 64'd1);
            if (!acc) return;
        end
        check("ready_drop", 64'(s_ready), 64'd0);
        waited = 0;
        while (!res_valid && waited < LAT + 4) begin
            @(posedge clk); #1;
            waited++;
        end
        check("res_latency", 64'(waited), 64'(LAT));
        exp_res = ref_sum(n);
        check("res",       64'(res),  64'(exp_res));
        check("done_busy", 64'(busy), 64'd0);
        check("done_err",  64'(err),  64'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_strobe",  64'(res_valid), 64'd0);
            check("idle_busy",    64'(busy),      64'd0);
            check("idle_dsp_ce",  64'(dsp_ce),    64'd0);
            check("idle_dsp_rst", 64'(dsp_rst),   64'd0);
            check("idle_res",     64'(res),       64'(exp_res));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_res",       64'(res),        64'd0);
        check("rst_res_valid", 64'(res_valid),  64'd0);
        check("rst_busy",      64'(busy),       64'd0);
        check("rst_err",       64'(err),        64'd0);
        check("rst_s_ready",   64'(s_ready),    64'd0);
        check("rst_dsp_a",     64'(dsp_a),      64'd0);
        check("rst_dsp_b",     64'(dsp_b),      64'd0);
        check("rst_opmode",    64'(dsp_opmode), 64'd0);
        check("rst_dsp_ce",    64'(dsp_ce),     64'd0);
        check("rst_dsp_rst",   64'(dsp_rst),    64'd1);
    endtask

    // Hard stop if the run wanders off
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        start   = 1'b0;
        ntaps   = '0;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_sub   = 1'b0;
        exp_res = '0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Three beats, no stalls: 6 + 20 - 42 = -16
        ja[0] = 18'sd2;  jb[0] = 18'sd3; js[0] = 1'b0; jst[0] = 0;
        ja[1] = 18'sd4;  jb[1] = 18'sd5; js[1] = 1'b0; jst[1] = 0;
        ja[2] = -18'sd6; jb[2] = 18'sd7; js[2] = 1'b0; jst[2] = 0;
        run_job(3, 1'b0);
        check("t1_res_const", 64'(res), 64'h0000_FFFF_FFFF_FFF0);
        idle_cycles(2);

        // Two beats with a five-cycle stall: 10000 - 50 = 9950
        ja[0] = 18'sd100; jb[0] = 18'sd100; js[0] = 1'b0; jst[0] = 0;
        ja[1] = 18'sd1;   jb[1] = 18'sd50;  js[1] = 1'b1; jst[1] = 5;
        run_job(2, 1'b0);
        check("t2_res_const", 64'(res), 64'd9950);
        idle_cycles(1);

        // START with NTAPS=0
        start = 1'b1;
        ntaps = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_strobe", 64'(err),       64'd1);
        check("err_busy",   64'(busy),      64'd0);
        check("err_dsp_ce", 64'(dsp_ce),    64'd0);
        check("err_res",    64'(res),       64'(exp_res));
        check("err_rv",     64'(res_valid), 64'd0);
        @(posedge clk); #1;
        check("err_width",  64'(err),       64'd0);
        check("err_busy2",  64'(busy),      64'd0);
        idle_cycles(1);

        // Back-to-back jobs, second one started in the RES_VALID cycle
        for (int i = 0; i < 3; i++) begin
            ja[i] = rand18(); jb[i] = rand18(); js[i] = 1'($urandom); jst[i] = 0;
        end
        run_job(3, 1'b0);
        ja[0] = -18'sd131072; jb[0] = -18'sd131072; js[0] = 1'b0; jst[0] = 0;
        run_job(1, 1'b0);
        check("t4_res_const", 64'(res), 64'h0000_0004_0000_0000);
        idle_cycles(1);

        // START pulsed while busy is ignored
        for (int i = 0; i < 4; i++) begin
            ja[i] = rand18(); jb[i] = rand18(); js[i] = 1'($urandom); jst[i] = 1;
        end
        jst[1] = 2;
        run_job(4, 1'b1);
        idle_cycles(1);

        // Reset in the middle of FEED of a 4-beat job
        start = 1'b1;
        ntaps = NW'(4);
        @(posedge clk); #1;              // CLR
        start   = 1'b0;
        s_valid = 1'b1;
        s_a     = 18'sd1234;
        s_b     = 18'sd567;
        s_sub   = 1'b0;
        @(posedge clk); #1;              // FEED, first beat offered
        @(posedge clk); #1;              // first beat taken
        @(posedge clk); #1;              // second beat taken
        check("pre_rst_ready", 64'(s_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        check_reset_outputs();
        s_valid = 1'b0;
        rst_n   = 1'b1;
        exp_res = '0;
        idle_cycles(6);
        ja[0] = 18'sd3; jb[0] = 18'sd3; js[0] = 1'b0; jst[0] = 0;
        run_job(1, 1'b0);
        check("t5_res_const", 64'(res), 64'd9);
        idle_cycles(1);

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                ja[i]  = rand18();
                jb[i]  = rand18();
                js[i]  = 1'($urandom);
                jst[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            if (n >= 2 && jst[1] == 0) jst[1] = 1;
            run_job(n, (n >= 2) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
